// File: rtl/pred_result_buffer_if.sv
// Groups the classifier write port and the AXI-Stream drain port of the prediction buffer.
// Latency: none; this is wiring only.
// Backpressure: out_TREADY flows from master to slave; the write port has no backpressure.
interface pred_result_buffer_if #(
    parameter int PRED_BITS      = 2,
    parameter int BRAM_ADDR_BITS = 14,
    parameter int DATA_WIDTH     = 32
);
    // Prediction write port, driven by the classifier
    logic [BRAM_ADDR_BITS-1:0] in_ADDR;
    logic [PRED_BITS-1:0]      in_DATA;
    logic                      in_WE;

    // Packed prediction stream, consumed by the PS/DMA
    logic [DATA_WIDTH-1:0]     out_TDATA;
    logic                      out_TVALID;
    logic                      out_TREADY;
    logic                      out_TLAST;

    // Host/producer side
    modport master (
        output in_ADDR, in_DATA, in_WE, out_TREADY,
        input  out_TDATA, out_TVALID, out_TLAST
    );

    // Buffer side
    modport slave (
        input  in_ADDR, in_DATA, in_WE, out_TREADY,
        output out_TDATA, out_TVALID, out_TLAST
    );
endinterface

// File: rtl/pred_result_buffer.sv
// Stores classifier predictions, keeps a saturating per-class histogram, and drains them as packed AXIS words.
// Latency: rd_start -> first TVALID after PACK+2 cycles; PACK+1 idle cycles between words.
// Backpressure: TDATA/TLAST held in SEND until TREADY; writes arriving while busy are dropped and flagged.
module pred_result_buffer #(
    parameter int PRED_BITS      = 2,
    parameter int BRAM_ADDR_BITS = 14,
    parameter int DATA_WIDTH     = 32,
    parameter int CNT_W          = 16
) (
    input  logic                               ap_clk,
    input  logic                               ap_rst_n,
    pred_result_buffer_if.slave                bus,
    input  logic                               clear,
    input  logic                               rd_start,
    output logic [(1<<PRED_BITS)*CNT_W-1:0]    hist_cnt,
    output logic                               busy,
    output logic                               drop_err
);
    localparam int DEPTH     = 1 << BRAM_ADDR_BITS;
    localparam int PACK      = DATA_WIDTH / PRED_BITS;
    localparam int PACK_LOG  = $clog2(PACK);
    localparam int WORD_BITS = BRAM_ADDR_BITS - PACK_LOG;
    localparam int NCLASS    = 1 << PRED_BITS;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_WAITRD = 2'd2,
        S_SEND   = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Capture / histogram state
    logic [BRAM_ADDR_BITS-1:0] hi_addr_q;
    logic                      any_wr_q;
    logic                      drop_err_q;
    logic [CNT_W-1:0]          hist_q [NCLASS];

    // Drain state: word_q selects the output word, slot_q the entry within it
    logic [WORD_BITS-1:0]      word_q;
    logic [PACK_LOG-1:0]       slot_q;
    logic                      rd_vld_q;
    logic [PACK_LOG-1:0]       rd_slot_q;
    logic [PRED_BITS-1:0]      rd_dat_q;
    logic [DATA_WIDTH-1:0]     pack_q;

    logic [PRED_BITS-1:0]      mem [DEPTH];

    logic                      is_idle;
    logic                      wr_acc;
    logic                      wr_drop;
    logic                      start;
    logic [BRAM_ADDR_BITS-1:0] rd_addr;
    logic                      rd_en;
    logic                      last_word;
    logic                      hs;

    // Control decode; clear overrides every other request in the same cycle
    always_comb begin
        is_idle   = (state_q == S_IDLE);
        wr_acc    = bus.in_WE && is_idle && !clear;
        wr_drop   = bus.in_WE && !is_idle && !clear;
        start     = rd_start && is_idle && any_wr_q && !clear;
        rd_addr   = {word_q, slot_q};
        rd_en     = (state_q == S_FILL) && (rd_addr <= hi_addr_q);
        last_word = (word_q == hi_addr_q[BRAM_ADDR_BITS-1:PACK_LOG]);
        hs        = (state_q == S_SEND) && bus.out_TREADY;
    end

    // FSM state register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: FILL walks PACK slots, WAITRD absorbs the read latency, SEND holds for TREADY
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FILL;
            S_FILL:   if (slot_q == PACK_LOG'(PACK - 1)) state_d = S_WAITRD;
            S_WAITRD: state_d = S_SEND;
            S_SEND:   if (hs) state_d = last_word ? S_IDLE : S_FILL;
            default:  state_d = S_IDLE;
        endcase
        if (clear) state_d = S_IDLE;
    end

    // Prediction memory: write port from the classifier, synchronous read port for the drain
    always_ff @(posedge ap_clk) begin
        if (wr_acc) mem[bus.in_ADDR] <= bus.in_DATA;
        if (rd_en)  rd_dat_q <= mem[rd_addr];
    end

    // Histogram, high-water address and sticky drop flag; frozen while draining since writes are refused
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            hi_addr_q  <= '0;
            any_wr_q   <= 1'b0;
            drop_err_q <= 1'b0;
            for (int k = 0; k < NCLASS; k++) hist_q[k] <= '0;
        end else if (clear) begin
            hi_addr_q  <= '0;
            any_wr_q   <= 1'b0;
            drop_err_q <= 1'b0;
            for (int k = 0; k < NCLASS; k++) hist_q[k] <= '0;
        end else begin
            if (wr_acc) begin
                any_wr_q <= 1'b1;
                if (bus.in_ADDR > hi_addr_q) hi_addr_q <= bus.in_ADDR;
                if (hist_q[bus.in_DATA] != {CNT_W{1'b1}})
                    hist_q[bus.in_DATA] <= hist_q[bus.in_DATA] + 1'b1;
            end
            if (wr_drop) drop_err_q <= 1'b1;
        end
    end

    // Drain datapath: slot/word pointers and the pack register; slots never read stay zero
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            word_q    <= '0;
            slot_q    <= '0;
            rd_vld_q  <= 1'b0;
            rd_slot_q <= '0;
            pack_q    <= '0;
        end else begin
            rd_vld_q  <= rd_en && !clear;
            rd_slot_q <= slot_q;
            if (clear) begin
                word_q <= '0;
                slot_q <= '0;
                pack_q <= '0;
            end else if (start) begin
                word_q <= '0;
                slot_q <= '0;
                pack_q <= '0;
            end else if (hs) begin
                slot_q <= '0;
                pack_q <= '0;
                if (!last_word) word_q <= word_q + 1'b1;
            end else begin
                if (state_q == S_FILL) slot_q <= slot_q + 1'b1;
                if (rd_vld_q) pack_q[int'(rd_slot_q)*PRED_BITS +: PRED_BITS] <= rd_dat_q;
            end
        end
    end

    // Histogram output packing, class k at [k*CNT_W +: CNT_W]
    for (genvar k = 0; k < NCLASS; k++) begin : g_hist
        assign hist_cnt[k*CNT_W +: CNT_W] = hist_q[k];
    end

    assign bus.out_TDATA  = pack_q;
    assign bus.out_TVALID = (state_q == S_SEND);
    assign bus.out_TLAST  = (state_q == S_SEND) && last_word;
    assign busy           = !is_idle;
    assign drop_err       = drop_err_q;

endmodule

// File: tb/tb_pred_result_buffer.sv
// Directed bench for pred_result_buffer: capture, packing, latency, backpressure, drop/clear, saturation.
// Latency: checks first TVALID exactly PACK+2 cycles after rd_start.
// Backpressure: holds TREADY low in SEND and checks the word stays stable.
module tb_pred_result_buffer;
    localparam int PRED_BITS      = 2;
    localparam int BRAM_ADDR_BITS = 14;
    localparam int DATA_WIDTH     = 32;
    localparam int CNT_W          = 16;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        clear;
    logic        rd_start;
    logic [63:0] hist_cnt;
    logic        busy;
    logic        drop_err;

    int n_chk;
    int n_bad;

    pred_result_buffer_if #(
        .PRED_BITS(PRED_BITS), .BRAM_ADDR_BITS(BRAM_ADDR_BITS), .DATA_WIDTH(DATA_WIDTH)
    ) bus ();

    pred_result_buffer #(
        .PRED_BITS(PRED_BITS), .BRAM_ADDR_BITS(BRAM_ADDR_BITS),
        .DATA_WIDTH(DATA_WIDTH), .CNT_W(CNT_W)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus),
        .clear    (clear),
        .rd_start (rd_start),
        .hist_cnt (hist_cnt),
        .busy     (busy),
        .drop_err (drop_err)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic write1(input int addr, input int data);
        bus.in_ADDR = addr[BRAM_ADDR_BITS-1:0];
        bus.in_DATA = data[PRED_BITS-1:0];
        bus.in_WE   = 1'b1;
        tick();
        bus.in_WE   = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic pulse_start();
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bus.out_TVALID && n < 100) begin
            tick();
            n++;
        end
        check(tag, 64'(bus.out_TVALID), 64'd1);
    endtask

    // Waits for a word and consumes it with one TREADY-high edge
    task automatic get_word(input string tag, output logic [31:0] d, output logic l);
        wait_valid(tag);
        d = bus.out_TDATA;
        l = bus.out_TLAST;
        bus.out_TREADY = 1'b1;
        tick();
    endtask

    initial begin
        logic [31:0] wd;
        logic        wl;
        logic        seen;

        n_chk = 0;
        n_bad = 0;
        ap_rst_n       = 1'b0;
        clear          = 1'b0;
        rd_start       = 1'b0;
        bus.in_ADDR    = '0;
        bus.in_DATA    = '0;
        bus.in_WE      = 1'b0;
        bus.out_TREADY = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_tvalid", 64'(bus.out_TVALID), 64'd0);
        check("rst_tlast",  64'(bus.out_TLAST),  64'd0);
        check("rst_tdata",  64'(bus.out_TDATA),  64'd0);
        check("rst_hist",   hist_cnt,            64'd0);
        check("rst_busy",   64'(busy),           64'd0);
        check("rst_drop",   64'(drop_err),       64'd0);
        ap_rst_n = 1'b1;
        tick();

        // 1: one full word of pattern 0,1,2,3 -> 0xE4 per byte, exact first-word latency
        for (int k = 0; k < 16; k++) write1(k, k % 4);
        check("t1_hist", hist_cnt, 64'h0004_0004_0004_0004);
        bus.out_TREADY = 1'b1;
        pulse_start();
        check("t1_busy", 64'(busy), 64'd1);
        repeat (16) tick();
        check("t1_valid_c17", 64'(bus.out_TVALID), 64'd0);
        tick();
        check("t1_valid_c18", 64'(bus.out_TVALID), 64'd1);
        check("t1_tdata",     64'(bus.out_TDATA),  64'hE4E4_E4E4);
        check("t1_tlast",     64'(bus.out_TLAST),  64'd1);
        tick();
        check("t1_busy_end",  64'(busy),           64'd0);
        check("t1_valid_end", 64'(bus.out_TVALID), 64'd0);

        // 2: entry 0 = 0, entries 1..20 = 3 -> two words; addresses 16..20 fill five slots of word 1
        pulse_clear();
        write1(0, 0);
        for (int k = 1; k <= 20; k++) write1(k, 3);
        check("t2_hist", hist_cnt, 64'h0014_0000_0000_0001);
        pulse_start();
        get_word("t2_w0_wait", wd, wl);
        check("t2_w0_data", 64'(wd), 64'hFFFF_FFFC);
        check("t2_w0_last", 64'(wl), 64'd0);
        get_word("t2_w1_wait", wd, wl);
        check("t2_w1_data", 64'(wd), 64'h0000_03FF);
        check("t2_w1_last", 64'(wl), 64'd1);
        check("t2_busy_end", 64'(busy), 64'd0);

        // 3: backpressure, word 0 must hold for 10 cycles then transfer once
        bus.out_TREADY = 1'b0;
        pulse_start();
        wait_valid("t3_wait");
        for (int c = 0; c < 10; c++) begin
            tick();
            check("t3_hold_valid", 64'(bus.out_TVALID), 64'd1);
            check("t3_hold_data",  64'(bus.out_TDATA),  64'hFFFF_FFFC);
            check("t3_hold_last",  64'(bus.out_TLAST),  64'd0);
        end
        bus.out_TREADY = 1'b1;
        tick();
        bus.out_TREADY = 1'b0;
        check("t3_single_xfer", 64'(bus.out_TVALID), 64'd0);
        check("t3_still_busy",  64'(busy),           64'd1);

        // 4: write during drain is dropped; memory and histogram untouched
        write1(16, 0);
        check("t4_drop_set",  64'(drop_err), 64'd1);
        check("t4_hist_same", hist_cnt,      64'h0014_0000_0000_0001);
        get_word("t4_w1_wait", wd, wl);
        check("t4_w1_data", 64'(wd), 64'h0000_03FF);
        check("t4_w1_last", 64'(wl), 64'd1);
        check("t4_drop_sticky", 64'(drop_err), 64'd1);
        pulse_clear();
        check("t4_drop_clr", 64'(drop_err), 64'd0);
        check("t4_hist_clr", hist_cnt,      64'd0);
        // Same-cycle clear and write: write lost, no drop flag
        clear       = 1'b1;
        bus.in_ADDR = 14'd3;
        bus.in_DATA = 2'd2;
        bus.in_WE   = 1'b1;
        tick();
        clear     = 1'b0;
        bus.in_WE = 1'b0;
        check("t4_clrwe_hist", hist_cnt,      64'd0);
        check("t4_clrwe_drop", 64'(drop_err), 64'd0);
        pulse_start();
        check("t4_start_nowr", 64'(busy), 64'd0);

        // 5: class-1 counter saturation, addresses wrap through the whole memory
        bus.in_DATA = 2'd1;
        bus.in_WE   = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            bus.in_ADDR = 14'(i);
            tick();
        end
        bus.in_WE = 1'b0;
        check("t5_hist_fffe", hist_cnt, 64'h0000_0000_FFFE_0000);
        for (int i = 0; i < 3; i++) write1(i, 1);
        check("t5_hist_sat", hist_cnt, 64'h0000_0000_FFFF_0000);
        pulse_clear();

        // 6: clear during SEND aborts at once; later rd_start with no writes does nothing
        for (int k = 0; k < 4; k++) write1(k, 2);
        bus.out_TREADY = 1'b0;
        pulse_start();
        wait_valid("t6_wait");
        check("t6_tdata", 64'(bus.out_TDATA), 64'h0000_00AA);
        check("t6_tlast", 64'(bus.out_TLAST), 64'd1);
        pulse_clear();
        check("t6_abort_valid", 64'(bus.out_TVALID), 64'd0);
        check("t6_abort_last",  64'(bus.out_TLAST),  64'd0);
        check("t6_abort_busy",  64'(busy),           64'd0);
        check("t6_abort_hist",  hist_cnt,            64'd0);
        bus.out_TREADY = 1'b1;
        pulse_start();
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            seen = seen | busy | bus.out_TVALID;
            tick();
        end
        check("t6_no_output", 64'(seen), 64'd0);

        // Reset in the middle of a drain
        write1(0, 1);
        pulse_start();
        repeat (5) tick();
        check("t7_busy_pre", 64'(busy), 64'd1);
        ap_rst_n = 1'b0;
        #1;
        check("t7_rst_busy",  64'(busy),           64'd0);
        check("t7_rst_valid", 64'(bus.out_TVALID), 64'd0);
        check("t7_rst_hist",  hist_cnt,            64'd0);
        tick();
        ap_rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
